ps2_key_event_filter: RTL and testbench

Parametrised successor to the PS/2 break-code filter. It sits after the PS/2 receiver and consumes its byte/tick stream. It decodes make, break (F0) and extended (E0) sequences, filters them against an accepted-key set, and optionally drops typematic repeats. Decoded key events are queued in a small FIFO read by the control FSM, and a legacy break pulse plus last-key register are kept for existing consumers.

---
 rtl/ps2_key_event_filter.sv | 228 ++++++++++++++++++++++
 tb/tb_ps2_key_event_filter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_key_event_filter: PS/2 make/break/extended decoder with key filter,  |
// | typematic repeat suppression and event FIFO.  Revision: 1.0              |
// +--------------------------------------------------------------------------+
module ps2_key_event_filter #(
  parameter int FIFO_DEPTH      = 4,
  parameter int FILTER_EN       = 1,
  parameter int REPORT_MAKE     = 1,
  parameter int REPORT_BREAK    = 1,
  parameter int REPEAT_SUPPRESS = 1,
  parameter int TIMEOUT_CYCLES  = 1_000_000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic [7:0]                    datain,
  input  logic                          ev_rd,
  input  logic                          ovf_clr,
  output logic                          ev_valid,
  output logic [9:0]                    ev_data,
  output logic [$clog2(FIFO_DEPTH):0]   ev_count,
  output logic                          overflow,
  output logic                          rx_tick,
  output logic [7:0]                    dataout
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXT  = 2'd1;
  localparam logic [1:0] ST_BRK  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             ext_q, ext_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [8:0]       held_q, held_d;
  logic             held_vld_q, held_vld_d;
  logic             rx_tick_q, rx_tick_d;
  logic [7:0]       dataout_q, dataout_d;
  logic             overflow_q, overflow_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [9:0]       mem_q [FIFO_DEPTH];
  logic [9:0]       mem_d [FIFO_DEPTH];

  logic       is_e0, is_f0;
  logic       make_hit, brk_hit, ev_ext;
  logic       is_repeat, push_req, do_push, do_pop, fifo_full;
  logic [9:0] push_data;

  function automatic logic key_ok(input logic ext, input logic [7:0] code);
    logic ok;
    ok = 1'b0;
    if (FILTER_EN != 0) begin
      if (!ext) begin
        case (code)
          8'h1C, 8'h24, 8'h4D, 8'h3A, 8'h1B, 8'h16,
          8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h45: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end else begin
        case (code)
          8'h75, 8'h72, 8'h6B, 8'h74: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
    end else begin
      case (code)
        8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hFE: ok = 1'b0;
        default: ok = 1'b1;
      endcase
    end
    return ok;
  endfunction

  assign is_e0 = (datain == 8'hE0);
  assign is_f0 = (datain == 8'hF0);

  // State register and all other flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ext_q      <= 1'b0;
      to_cnt_q   <= '0;
      held_q     <= '0;
      held_vld_q <= 1'b0;
      rx_tick_q  <= 1'b0;
      dataout_q  <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ext_q      <= ext_d;
      to_cnt_q   <= to_cnt_d;
      held_q     <= held_d;
      held_vld_q <= held_vld_d;
      rx_tick_q  <= rx_tick_d;
      dataout_q  <= dataout_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Next-state logic, including prefix abandonment after a quiet period
  always_comb begin
    state_d  = state_q;
    ext_d    = ext_q;
    to_cnt_d = to_cnt_q;
    if (tick) begin
      to_cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (is_e0) begin
            state_d = ST_EXT;
          end else if (is_f0) begin
            state_d = ST_BRK;
            ext_d   = 1'b0;
          end
        end
        ST_EXT: begin
          if (is_f0) begin
            state_d = ST_BRK;
            ext_d   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (!is_f0) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && TIMEOUT_CYCLES != 0) begin
      if (to_cnt_q == TO_W'(TO_LAST)) begin
        state_d  = ST_IDLE;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  // Output decode: which event, if any, the current byte completes
  always_comb begin
    make_hit = 1'b0;
    brk_hit  = 1'b0;
    ev_ext   = 1'b0;
    if (tick && !is_f0 && !is_e0) begin
      case (state_q)
        ST_IDLE: make_hit = key_ok(1'b0, datain);
        ST_EXT: begin
          make_hit = key_ok(1'b1, datain);
          ev_ext   = 1'b1;
        end
        ST_BRK: begin
          brk_hit = key_ok(ext_q, datain);
          ev_ext  = ext_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    is_repeat  = (REPEAT_SUPPRESS != 0) && held_vld_q && (held_q == {ev_ext, datain});
    held_d     = held_q;
    held_vld_d = held_vld_q;
    if (REPEAT_SUPPRESS != 0) begin
      if (make_hit && !is_repeat) begin
        held_d     = {ev_ext, datain};
        held_vld_d = 1'b1;
      end else if (brk_hit && held_vld_q && held_q == {ev_ext, datain}) begin
        held_vld_d = 1'b0;
      end
    end

    push_req  = (make_hit && !is_repeat && REPORT_MAKE != 0) ||
                (brk_hit && REPORT_BREAK != 0);
    push_data = {ev_ext, brk_hit, datain};

    rx_tick_d = brk_hit;
    dataout_d = brk_hit ? {1'b0, datain[6:0]} : dataout_q;
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle
  always_comb begin
    fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    do_pop    = ev_rd && (count_q != '0);
    do_push   = push_req && (!fifo_full || do_pop);

    for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;

    if (push_req && fifo_full && !do_pop) overflow_d = 1'b1;
    else if (ovf_clr)                     overflow_d = 1'b0;
    else                                  overflow_d = overflow_q;
  end

  assign ev_valid = (count_q != '0);
  assign ev_data  = ev_valid ? mem_q[rd_ptr_q] : 10'd0;
  assign ev_count = count_q;
  assign overflow = overflow_q;
  assign rx_tick  = rx_tick_q;
  assign dataout  = dataout_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ps2_key_event_filter: directed self-checking bench. Revision: 1.0     |
// +--------------------------------------------------------------------------+
module tb_ps2_key_event_filter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] datain = 8'h00;
  logic       ev_rd = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       ev_valid;
  logic [9:0] ev_data;
  logic [2:0] ev_count;
  logic       overflow;
  logic       rx_tick;
  logic [7:0] dataout;

  int n_cmp = 0;
  int n_bad = 0;

  ps2_key_event_filter #(
    .FIFO_DEPTH(4), .FILTER_EN(1), .REPORT_MAKE(1), .REPORT_BREAK(1),
    .REPEAT_SUPPRESS(1), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .datain(datain),
    .ev_rd(ev_rd), .ovf_clr(ovf_clr), .ev_valid(ev_valid), .ev_data(ev_data),
    .ev_count(ev_count), .overflow(overflow), .rx_tick(rx_tick), .dataout(dataout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic send(input logic [7:0] b);
    tick = 1'b1; datain = b;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic pop();
    ev_rd = 1'b1;
    @(negedge clk);
    ev_rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_valid", ev_valid, 0);
    check("rst_data", ev_data, 0);
    check("rst_count", ev_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_rxtick", rx_tick, 0);
    check("rst_dataout", dataout, 0);

    // Plain make then break
    send(8'h1C);
    check("make_valid", ev_valid, 1);
    check("make_data", ev_data, 10'h01C);
    check("make_rxtick", rx_tick, 0);
    send(8'hF0);
    send(8'h1C);
    check("brk_rxtick", rx_tick, 1);
    check("brk_dataout", dataout, 8'h1C);
    check("brk_count", ev_count, 2);
    idle(1);
    check("brk_rxtick_once", rx_tick, 0);
    pop();
    check("brk_data", ev_data, 10'h11C);
    pop();
    check("drain1", ev_count, 0);

    // Extended keys
    send(8'hE0); send(8'h75);
    check("ext_make", ev_data, 10'h275);
    pop();
    send(8'hE0); send(8'hF0); send(8'h75);
    check("ext_brk", ev_data, 10'h375);
    check("ext_brk_rxtick", rx_tick, 1);
    check("ext_brk_dataout", dataout, 8'h75);
    pop();
    send(8'hE0); send(8'h11);
    check("ext_reject", ev_count, 0);
    send(8'h24);
    check("idle_after_reject", ev_data, 10'h024);
    pop();

    // Typematic repeat suppression
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    check("rep_count", ev_count, 3);
    check("rep_ev0", ev_data, 10'h01C);
    pop();
    check("rep_ev1", ev_data, 10'h11C);
    pop();
    check("rep_ev2", ev_data, 10'h01C);
    pop();
    check("rep_drain", ev_count, 0);

    // FIFO overflow and full-boundary behaviour
    send(8'h24); send(8'h4D); send(8'h3A); send(8'h1B); send(8'h16); send(8'h1E);
    check("full_count", ev_count, 4);
    check("full_ovf", overflow, 1);
    check("full_head", ev_data, 10'h024);
    ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);
    ev_rd = 1'b1; send(8'h26); ev_rd = 1'b0;
    check("pushpop_full_count", ev_count, 4);
    check("pushpop_full_ovf", overflow, 0);
    check("pushpop_full_head", ev_data, 10'h04D);
    ovf_clr = 1'b1; send(8'h25); ovf_clr = 1'b0;
    check("ovf_set_wins", overflow, 1);
    check("ovf_set_count", ev_count, 4);
    ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
    check("ovf_clr2", overflow, 0);
    pop(); pop(); pop();
    check("wrap_tail", ev_data, 10'h026);
    pop();
    check("full_drain", ev_count, 0);
    pop();
    check("pop_empty_count", ev_count, 0);
    check("pop_empty_valid", ev_valid, 0);
    ev_rd = 1'b1; send(8'h36); ev_rd = 1'b0;
    check("pushpop_empty_count", ev_count, 1);
    check("pushpop_empty_data", ev_data, 10'h036);
    pop();

    // Prefix timeout
    send(8'hF0); idle(16); send(8'h1C);
    check("to_make", ev_data, 10'h01C);
    check("to_make_rxtick", rx_tick, 0);
    pop();
    send(8'hF0); idle(10); send(8'h1C);
    check("to_brk", ev_data, 10'h11C);
    check("to_brk_rxtick", rx_tick, 1);
    pop();
    check("to_drain", ev_count, 0);

    // Reset in the middle of a break sequence
    send(8'h4D);
    send(8'hF0);
    reset = 1'b1; idle(1); reset = 1'b0;
    check("midrst_count", ev_count, 0);
    check("midrst_rxtick", rx_tick, 0);
    send(8'h1C);
    check("midrst_make", ev_data, 10'h01C);
    check("midrst_make_rxtick", rx_tick, 0);
    check("midrst_dataout", dataout, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
